// File: rtl/puf_pkg.sv
// Shared state encoding and default sizing for the PUF response collector.
package puf_pkg;

  localparam int NBITS_DEF   = 64;
  localparam int SEL_W_DEF   = 6;
  localparam int CW_DEF      = 32;
  localparam int TIMEOUT_DEF = 1 << 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

endpackage

// File: rtl/puf_bit_decide.sv
// Turns one oscillator race into a response bit; purely combinational, no backpressure.
// A finish always wins over the timeout, and a tie or timeout yields 0.
module puf_bit_decide
  import puf_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic [CW-1:0] i_cnt_a,
  input  logic [CW-1:0] i_cnt_b,
  input  logic          i_fin_a,
  input  logic          i_fin_b,
  input  logic          i_tmo_last,
  output logic          o_bit,
  output logic          o_timeout_hit
);

  logic w_fin;

  assign w_fin         = i_fin_a | i_fin_b;
  assign o_bit         = w_fin && (i_cnt_a > i_cnt_b);
  assign o_timeout_hit = !w_fin && i_tmo_last;

endmodule

// File: rtl/puf_response_collector.sv
// Sequences NBITS challenges (CLEAR, RUN until finish/timeout, CAPTURE) into one response word.
// All outputs registered; valid pulses one cycle after the last CAPTURE; start ignored unless IDLE.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int CW      = CW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [CW-1:0]    i_cnt_a,
  input  logic [CW-1:0]    i_cnt_b,
  input  logic             i_fin_a,
  input  logic             i_fin_b,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_ro_en,
  output logic             o_cnt_clear,
  output logic             o_busy,
  output logic [NBITS-1:0] o_response,
  output logic             o_valid,
  output logic             o_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NBITS - 1);

  state_t           r_state, w_nxt_state;
  logic [SEL_W-1:0] r_idx, w_nxt_idx;
  logic [TW-1:0]    r_tmo, w_nxt_tmo;
  logic             r_bit, w_nxt_bit;
  logic [NBITS-1:0] r_response, w_nxt_response;
  logic             r_err, w_nxt_err;
  logic             r_ro_en, r_cnt_clear, r_busy, r_valid;
  logic             w_bit, w_timeout_hit;

  puf_bit_decide #(.CW(CW)) u_decide (
    .i_cnt_a       (i_cnt_a),
    .i_cnt_b       (i_cnt_b),
    .i_fin_a       (i_fin_a),
    .i_fin_b       (i_fin_b),
    .i_tmo_last    (r_tmo == TMO_LAST),
    .o_bit         (w_bit),
    .o_timeout_hit (w_timeout_hit)
  );

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_idx      = r_idx;
    w_nxt_tmo      = r_tmo;
    w_nxt_bit      = r_bit;
    w_nxt_response = r_response;
    w_nxt_err      = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nxt_state    = S_CLEAR;
          w_nxt_idx      = '0;
          w_nxt_response = '0;
          w_nxt_err      = 1'b0;
        end
      end
      S_CLEAR: begin
        w_nxt_tmo   = '0;
        w_nxt_state = S_RUN;
      end
      S_RUN: begin
        w_nxt_tmo = r_tmo + TW'(1);
        // The bit is latched with the counts of the finishing cycle itself.
        if (i_fin_a || i_fin_b || w_timeout_hit) begin
          w_nxt_state = S_CAPTURE;
          w_nxt_bit   = w_bit;
          if (w_timeout_hit) w_nxt_err = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_nxt_response = {r_response[NBITS-2:0], r_bit};
        if (r_idx == IDX_LAST) begin
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_idx   = r_idx + SEL_W'(1);
          w_nxt_state = S_CLEAR;
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_bit       <= 1'b0;
      r_response  <= '0;
      r_err       <= 1'b0;
      r_ro_en     <= 1'b0;
      r_cnt_clear <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_idx       <= w_nxt_idx;
      r_tmo       <= w_nxt_tmo;
      r_bit       <= w_nxt_bit;
      r_response  <= w_nxt_response;
      r_err       <= w_nxt_err;
      r_ro_en     <= (w_nxt_state == S_RUN);
      r_cnt_clear <= (w_nxt_state == S_CLEAR);
      r_busy      <= (w_nxt_state != S_IDLE);
      r_valid     <= (w_nxt_state == S_DONE);
    end
  end

  assign o_sel       = r_idx;
  assign o_ro_en     = r_ro_en;
  assign o_cnt_clear = r_cnt_clear;
  assign o_busy      = r_busy;
  assign o_response  = r_response;
  assign o_valid     = r_valid;
  assign o_err       = r_err;

endmodule

// File: doc/puf_response_collector.md
# puf_response_collector

Sequencer and bit collector that sits directly downstream of the pair of post-mux edge counters in the 64-bit PUF RNG. For each of NBITS challenges it selects a ring-oscillator pair through the mux, clears and runs both counters, and converts the race between them into one response bit. It assembles the 64-bit response word and flags it valid.

## Interface
- NBITS, 64: response bits per run; one challenge per bit.
- SEL_W, 6: mux select width; must satisfy 2^SEL_W ≥ NBITS.
- CW, 32: counter width; matches the post-mux counters.
- TIMEOUT, 2^20: maximum RUN cycles per challenge before forcing the bit.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- cnt_a  in  CW  count value from counter A.
- cnt_b  in  CW  count value from counter B.
- fin_a  in  1  finished flag from counter A.
- fin_b  in  1  finished flag from counter B.
- sel  out  SEL_W  challenge index driven to the oscillator mux pair.
- ro_en  out  1  enables the selected oscillators and counter increments.
- cnt_clear  out  1  active-high clear driven to both counters' reset.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- response  out  NBITS  assembled response; holds its value until the next accepted start.
- valid  out  1  one-cycle pulse when response is complete.
- err  out  1  sticky timeout flag; cleared on accepted start.

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE, DONE.
- IDLE: start=1 → CLEAR. Same edge: idx=0, response=0, err=0.
- CLEAR, one cycle:
  - cnt_clear=1, ro_en=0, sel=idx.
  - Timeout counter reset.
  - → RUN.
- RUN:
  - ro_en=1; timeout counter increments each cycle.
  - fin_a|fin_b → CAPTURE. bit = (cnt_a > cnt_b), unsigned; equal gives 0.
  - Timeout counter reaching TIMEOUT-1 without a finish → CAPTURE with bit=0; err set.
  - Finish takes priority over timeout on the same cycle.
- CAPTURE, one cycle:
  - ro_en=0; response = {response[NBITS-2:0], bit}.
  - Challenge 0 ends in the MSB.
  - idx==NBITS-1 → DONE; else idx+1 → CLEAR.
- DONE, one cycle: valid=1, → IDLE.
- start is ignored in every state other than IDLE.
- sel is stable for the whole CLEAR/RUN/CAPTURE of a challenge.

## Timing
- Reset values:
  - sel=0, ro_en=0, cnt_clear=0, busy=0, response=0, valid=0, err=0.
  - State IDLE, idx=0.
  - All outputs are registered.
- start sampled at edge t → CLEAR active in cycle t+1.
- Per challenge: 1 (CLEAR) + k (RUN, k = cycles until a finish flag is seen, ≤ TIMEOUT) + 1 (CAPTURE).
- valid follows the last CAPTURE by one cycle. response is already final during the valid cycle.
- fin flags are registered by the counters. The compare uses cnt values from the same cycle as the finish.
- Reset asserted mid-run: immediate return to reset values. The counters see cnt_clear=0, so the run is abandoned; the next start reclears the counters.

## Structure
- Shared package (puf_pkg): state encoding enum, NBITS/SEL_W/CW defaults.
- Sub-module puf_bit_decide: combinational compare of cnt_a/cnt_b plus the timeout override, producing bit and timeout_hit. All sequencing stays in the top.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0. Release, no start → stays IDLE for 100 cycles.
- Alternating race: counter model finishes A first for even sel, B first for odd → response=0xAAAA_AAAA_AAAA_AAAA, valid a single pulse, err=0.
- Tie and margin:
  - fin_a=fin_b=1 with cnt_a=cnt_b=0x8000_0000 → bit 0.
  - cnt_a=0x8000_0000, cnt_b=0x7FFF_FFFF → bit 1.
- Timeout: TIMEOUT=16, counters never finish → response=0, err=1, valid exactly 64×18+1 cycles after start.
- Busy/abort:
  - start pulsed at bit 5 → ignored, result unchanged.
  - reset dropped at bit 10 → outputs zeroed. A fresh start then yields a complete correct 64-bit response.
